// File: rtl/axi_cfg_master_pkg.sv
// rtl/axi_cfg_master_pkg.sv - shared types and AXI constants for axi_cfg_master
// Purpose: FSM state enum, AXI4 field encodings and the latched command struct.
// Ports: none (package).
package axi_cfg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RR,
    ST_RSP
  } cfg_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_4B     = 3'd2;

  // Offsets are held at a fixed 32-bit width so the struct stays packed
  // independent of the module's OFFSET_WIDTH parameter.
  localparam int CMD_OFFSET_MAX_W = 32;

  typedef struct packed {
    logic                        write;
    logic [CMD_OFFSET_MAX_W-1:0] offset;
    logic [31:0]                 wdata;
  } cfg_cmd_t;

endpackage

// File: rtl/axi_cfg_master_if.sv
// rtl/axi_cfg_master_if.sv - command/response streams and AXI4 master bus of axi_cfg_master
// Purpose: bundles every handshake/bus signal of the configuration master.
// Signals: cmd_* command stream (into the master), rsp_* response stream (out of
//          the master), m_axi_aw/w/b/ar/r AXI4 channels toward the accelerator.
// Modports: master = axi_cfg_master side, slave = host sequencer + AXI slave side.
interface axi_cfg_master_if #(
  parameter int AXIL_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int OFFSET_WIDTH    = 16
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [OFFSET_WIDTH-1:0]    cmd_offset;
  logic [31:0]                cmd_wdata;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_write;
  logic [31:0]                rsp_rdata;
  logic [1:0]                 rsp_resp;
  logic                       rsp_timeout;

  logic [AXI_ID_WIDTH-1:0]    m_axi_awid;
  logic [AXIL_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]                 m_axi_awlen;
  logic [2:0]                 m_axi_awsize;
  logic [1:0]                 m_axi_awburst;
  logic                       m_axi_awlock;
  logic [3:0]                 m_axi_awcache;
  logic [2:0]                 m_axi_awprot;
  logic                       m_axi_awvalid;
  logic                       m_axi_awready;

  logic [31:0]                m_axi_wdata;
  logic [3:0]                 m_axi_wstrb;
  logic                       m_axi_wlast;
  logic                       m_axi_wvalid;
  logic                       m_axi_wready;

  logic [AXI_ID_WIDTH-1:0]    m_axi_bid;
  logic [1:0]                 m_axi_bresp;
  logic                       m_axi_bvalid;
  logic                       m_axi_bready;

  logic [AXI_ID_WIDTH-1:0]    m_axi_arid;
  logic [AXIL_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic                       m_axi_arlock;
  logic [3:0]                 m_axi_arcache;
  logic [2:0]                 m_axi_arprot;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready;

  logic [AXI_ID_WIDTH-1:0]    m_axi_rid;
  logic [31:0]                m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_offset, cmd_wdata, rsp_ready,
    input  m_axi_awready, m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_offset, cmd_wdata, rsp_ready,
    output m_axi_awready, m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi_cfg_master.sv
// rtl/axi_cfg_master.sv - single-beat AXI4 configuration master driven by a command stream
// Purpose: turns word-offset read/write commands into one AXI4 transaction each at
//          AXIL_BASE_ADDR + 4*offset and returns one response per command.
// Ports:   clk, rstn (async active-low), bus (axi_cfg_master_if.master: cmd_*, rsp_*,
//          m_axi_* channels). Every output comes straight from a flop or a constant.
// Option:  define AXI_CFG_MASTER_TIMEOUT_EN to build the TIMEOUT_CYCLES watchdog;
//          without it rsp_timeout is tied low and the master waits indefinitely.
module axi_cfg_master
  import axi_cfg_master_pkg::*;
#(
  parameter int                         AXIL_ADDR_WIDTH = 40,
  parameter int                         AXIL_WIDTH      = 32,
  parameter int                         AXI_ID_WIDTH    = 6,
  parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
  parameter int                         OFFSET_WIDTH    = 16,
  parameter int                         TIMEOUT_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  axi_cfg_master_if.master bus
);

  localparam int STRB_W = AXIL_WIDTH / 8;

  cfg_state_t                 state_q, state_d;
  cfg_cmd_t                   cmd_q, cmd_d;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       bready_q, bready_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AXIL_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rsp_timeout_q, rsp_timeout_d;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
`endif

  // Returned IDs and rlast carry no information for single-beat, single-ID
  // traffic; the offset lives on in addr_q, so the latched copy is not read.
  logic unused_inputs;
  assign unused_inputs = ^{bus.m_axi_bid, bus.m_axi_rid, bus.m_axi_rlast, cmd_q.offset};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    timer_d       = timer_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.write  = bus.cmd_write;
          cmd_d.offset = CMD_OFFSET_MAX_W'(bus.cmd_offset);
          cmd_d.wdata  = bus.cmd_wdata;
          // Computed at the bus width so an oversized offset wraps, never widens.
          addr_d       = AXIL_BASE_ADDR + AXIL_ADDR_WIDTH'({cmd_d.offset, 2'b00});
          cmd_ready_d  = 1'b0;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
          timer_d       = '0;
          rsp_timeout_d = 1'b0;
`endif
          if (bus.cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RA;
          end
        end
      end

      ST_WR: begin
        // AW and W retire independently; leave once neither is pending.
        if (awvalid_q && bus.m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WB;
        end
      end

      ST_WB: begin
        if (bus.m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = bus.m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RA: begin
        if (bus.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RR;
        end
      end

      ST_RR: begin
        if (bus.m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = bus.m_axi_rdata;
          rsp_resp_d  = bus.m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    // A real response in the same cycle wins over the watchdog.
    if (state_q inside {ST_WR, ST_WB, ST_RA, ST_RR} && state_d != ST_RSP) begin
      if (timer_q == TIMER_W'(TIMEOUT_CYCLES)) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = 1'b1;
        rsp_resp_d    = RESP_SLVERR;
        rsp_rdata_d   = '0;
        state_d       = ST_RSP;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
      timer_q       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
      timer_q       <= timer_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = cmd_q.write;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_resp    = rsp_resp_q;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.m_axi_awid    = AXI_ID_WIDTH'(1);
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = SIZE_4B;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'd0;
  assign bus.m_axi_awprot  = 3'd0;
  assign bus.m_axi_awvalid = awvalid_q;

  assign bus.m_axi_wdata   = cmd_q.wdata;
  assign bus.m_axi_wstrb   = {STRB_W{1'b1}};
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = wvalid_q;

  assign bus.m_axi_bready  = bready_q;

  assign bus.m_axi_arid    = AXI_ID_WIDTH'(1);
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = SIZE_4B;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'd0;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arvalid = arvalid_q;

  assign bus.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_cfg_master.sv
// tb/tb_axi_cfg_master.sv - directed self-checking bench for axi_cfg_master
module tb_axi_cfg_master;
  import axi_cfg_master_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_cfg_master_if #(.AXIL_ADDR_WIDTH(40), .AXI_ID_WIDTH(6), .OFFSET_WIDTH(16)) bus ();

  axi_cfg_master #(
    .AXIL_ADDR_WIDTH(40), .AXIL_WIDTH(32), .AXI_ID_WIDTH(6),
    .AXIL_BASE_ADDR(40'h0), .OFFSET_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_offset = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bid = 6'd1; bus.m_axi_bresp = RESP_OKAY; bus.m_axi_bvalid = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid = 6'd1; bus.m_axi_rdata = '0; bus.m_axi_rresp = RESP_OKAY;
    bus.m_axi_rlast = 1'b1; bus.m_axi_rvalid = 1'b0;
  endtask

  task automatic put_cmd(input logic w, input logic [15:0] off, input logic [31:0] d);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_offset = off; bus.cmd_wdata = d;
  endtask

  task automatic rsp_pulse();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_handshakes: got %b want 00000",
        {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready}); end
    checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata} !== 37'h0) begin
      errors++; $display("FAIL reset_rsp: valid %b timeout %b write %b resp %h rdata %h want all 0",
        bus.rsp_valid, bus.rsp_timeout, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata); end
    checks++; if ({bus.m_axi_awid, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awlock,
                   bus.m_axi_awcache, bus.m_axi_awprot} !== {6'd1, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}) begin
      errors++; $display("FAIL aw_const_fields: id %h len %h size %h burst %h want 1 0 2 1",
        bus.m_axi_awid, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst); end
    checks++; if ({bus.m_axi_arid, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                   bus.m_axi_arcache, bus.m_axi_arprot} !== {6'd1, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0}) begin
      errors++; $display("FAIL ar_const_fields: id %h len %h size %h burst %h want 1 0 2 1",
        bus.m_axi_arid, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst); end
    checks++; if ({bus.m_axi_wstrb, bus.m_axi_wlast} !== 5'b11111) begin
      errors++; $display("FAIL w_const_fields: wstrb %h wlast %b want f 1", bus.m_axi_wstrb, bus.m_axi_wlast); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    idle_inputs();
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    put_cmd(1'b1, 16'd3, 32'hDEADBEEF);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready_c0: got %b want 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.cmd_ready} !== 3'b110) begin
      errors++; $display("FAIL wr_c1_valids: aw %b w %b cmd_ready %b want 1 1 0", bus.m_axi_awvalid, bus.m_axi_wvalid, bus.cmd_ready); end
    checks++; if (bus.m_axi_awaddr !== 40'h0C) begin errors++; $display("FAIL wr_awaddr: got %h want 0c", bus.m_axi_awaddr); end
    checks++; if (bus.m_axi_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", bus.m_axi_wdata); end
    tick();
    checks++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL wr_c2: aw %b w %b bready %b rsp_valid %b want 0 0 1 0",
        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.rsp_valid); end
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = RESP_OKAY;
    tick();
    bus.m_axi_bvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.m_axi_bready} !== 5'b11000) begin
      errors++; $display("FAIL wr_c3_rsp: valid %b write %b resp %h bready %b want 1 1 0 0",
        bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.m_axi_bready); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    rsp_pulse();
    checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL wr_c4_idle: rsp_valid %b cmd_ready %b want 0 1", bus.rsp_valid, bus.cmd_ready); end
  endtask

  task automatic test_read();
    idle_inputs();
    bus.m_axi_arready = 1'b1;
    put_cmd(1'b0, 16'd5, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.m_axi_arvalid, bus.cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL rd_c1: arvalid %b cmd_ready %b want 1 0", bus.m_axi_arvalid, bus.cmd_ready); end
    checks++; if (bus.m_axi_araddr !== 40'h14) begin errors++; $display("FAIL rd_araddr: got %h want 14", bus.m_axi_araddr); end
    tick();
    checks++; if ({bus.m_axi_arvalid, bus.m_axi_rready} !== 2'b01) begin
      errors++; $display("FAIL rd_c2: arvalid %b rready %b want 0 1", bus.m_axi_arvalid, bus.m_axi_rready); end
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h12345678; bus.m_axi_rresp = RESP_OKAY;
    tick();
    bus.m_axi_rvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_resp} !== 4'b1000) begin
      errors++; $display("FAIL rd_c3_rsp: valid %b write %b resp %h want 1 0 0", bus.rsp_valid, bus.rsp_write, bus.rsp_resp); end
    checks++; if (bus.rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", bus.rsp_rdata); end
    rsp_pulse();
  endtask

  task automatic test_error_resp();
    idle_inputs();
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    put_cmd(1'b1, 16'h0010, 32'h55);
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.m_axi_awaddr !== 40'h40) begin errors++; $display("FAIL err_awaddr: got %h want 40", bus.m_axi_awaddr); end
    tick();
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = RESP_DECERR;
    tick();
    bus.m_axi_bvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_resp} !== 3'b111) begin
      errors++; $display("FAIL err_decerr: valid %b resp %h want 1 3", bus.rsp_valid, bus.rsp_resp); end
    rsp_pulse();
    idle_inputs();
    bus.m_axi_arready = 1'b1;
    put_cmd(1'b0, 16'd1, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'hCAFE0001; bus.m_axi_rresp = RESP_SLVERR;
    tick();
    bus.m_axi_rvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata} !== {1'b1, 2'b10, 32'hCAFE0001}) begin
      errors++; $display("FAIL err_slverr: valid %b resp %h rdata %h want 1 2 cafe0001", bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata); end
    rsp_pulse();
  endtask

  task automatic test_aw_delay();
    idle_inputs();
    bus.m_axi_wready = 1'b1;
    put_cmd(1'b1, 16'd7, 32'hA5A50001);
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      logic exp_w;
      exp_w = (c == 1);
      checks++; if ({bus.m_axi_awvalid, bus.m_axi_awaddr} !== {1'b1, 40'h1C}) begin
        errors++; $display("FAIL awdly_aw_c%0d: awvalid %b awaddr %h want 1 1c", c, bus.m_axi_awvalid, bus.m_axi_awaddr); end
      checks++; if (bus.m_axi_wvalid !== exp_w) begin
        errors++; $display("FAIL awdly_wvalid_c%0d: got %b want %b", c, bus.m_axi_wvalid, exp_w); end
      checks++; if (bus.m_axi_bready !== 1'b0) begin
        errors++; $display("FAIL awdly_bready_c%0d: got %b want 0", c, bus.m_axi_bready); end
      if (c == 5) bus.m_axi_awready = 1'b1;
      tick();
    end
    bus.m_axi_awready = 1'b0;
    checks++; if ({bus.m_axi_awvalid, bus.m_axi_bready} !== 2'b01) begin
      errors++; $display("FAIL awdly_c6: awvalid %b bready %b want 0 1", bus.m_axi_awvalid, bus.m_axi_bready); end
    bus.m_axi_bvalid = 1'b1;
    tick();
    bus.m_axi_bvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_resp} !== 4'b1100) begin
      errors++; $display("FAIL awdly_rsp: valid %b write %b resp %h want 1 1 0", bus.rsp_valid, bus.rsp_write, bus.rsp_resp); end
    rsp_pulse();
  endtask

  task automatic test_rsp_backpressure();
    idle_inputs();
    bus.m_axi_arready = 1'b1;
    put_cmd(1'b0, 16'd2, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h0BADF00D;
    tick();
    bus.m_axi_rvalid = 1'b0;
    put_cmd(1'b0, 16'd9, 32'h0);
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata, bus.cmd_ready} !== {4'b1000, 32'h0BADF00D, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d: valid %b write %b resp %h rdata %h cmd_ready %b want 1 0 0 0badf00d 0",
          i, bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_rdata, bus.cmd_ready); end
      tick();
    end
    rsp_pulse();
    checks++; if ({bus.rsp_valid, bus.cmd_ready, bus.m_axi_arvalid} !== 3'b010) begin
      errors++; $display("FAIL bp_after_hs: rsp_valid %b cmd_ready %b arvalid %b want 0 1 0", bus.rsp_valid, bus.cmd_ready, bus.m_axi_arvalid); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.cmd_ready} !== {1'b1, 40'h24, 1'b0}) begin
      errors++; $display("FAIL bp_next_cmd: arvalid %b araddr %h cmd_ready %b want 1 24 0", bus.m_axi_arvalid, bus.m_axi_araddr, bus.cmd_ready); end
    tick();
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h11112222;
    tick();
    bus.m_axi_rvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h11112222}) begin
      errors++; $display("FAIL bp_next_rsp: valid %b rdata %h want 1 11112222", bus.rsp_valid, bus.rsp_rdata); end
    rsp_pulse();
  endtask

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int  n_bready;
    logic seen;
    idle_inputs();
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    put_cmd(1'b1, 16'd1, 32'h1);
    tick();
    bus.cmd_valid = 1'b0;
    n_bready = 0; seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      if (bus.m_axi_bready === 1'b1) n_bready++;
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_rsp_seen: no response within 64 cycles"); end
    checks++; if (n_bready != 16) begin errors++; $display("FAIL to_bready_cycles: got %0d want 16", n_bready); end
    checks++; if ({bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata, bus.m_axi_bready} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
      errors++; $display("FAIL to_rsp_fields: timeout %b resp %h rdata %h bready %b want 1 2 0 0",
        bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata, bus.m_axi_bready); end
    rsp_pulse();
    idle_inputs();
    bus.m_axi_arready = 1'b1;
    put_cmd(1'b0, 16'd6, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h0000600D;
    tick();
    bus.m_axi_rvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata} !== {4'b1000, 32'h0000600D}) begin
      errors++; $display("FAIL to_after_read: valid %b timeout %b resp %h rdata %h want 1 0 0 600d",
        bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata); end
    rsp_pulse();
  endtask
`else
  task automatic test_no_timeout();
    idle_inputs();
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    put_cmd(1'b1, 16'd1, 32'h1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      checks++; if ({bus.m_axi_bready, bus.rsp_valid} !== 2'b10) begin
        errors++; $display("FAIL nto_wait_%0d: bready %b rsp_valid %b want 1 0", i, bus.m_axi_bready, bus.rsp_valid); end
      tick();
    end
    bus.m_axi_bvalid = 1'b1;
    tick();
    bus.m_axi_bvalid = 1'b0;
    checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp} !== 4'b1000) begin
      errors++; $display("FAIL nto_rsp: valid %b timeout %b resp %h want 1 0 0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp); end
    rsp_pulse();
  endtask
`endif

  task automatic test_reset_mid();
    idle_inputs();
    put_cmd(1'b0, 16'd4, 32'h0);
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_arvalid_pre: got %b want 1", bus.m_axi_arvalid); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({bus.m_axi_arvalid, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_mid_async: arvalid %b cmd_ready %b want 0 1", bus.m_axi_arvalid, bus.cmd_ready); end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({bus.rsp_valid, bus.m_axi_arvalid, bus.m_axi_rready, bus.cmd_ready} !== 4'b0001) begin
        errors++; $display("FAIL rst_mid_after_%0d: rsp_valid %b arvalid %b rready %b cmd_ready %b want 0 0 0 1",
          i, bus.rsp_valid, bus.m_axi_arvalid, bus.m_axi_rready, bus.cmd_ready); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_error_resp();
    test_aw_delay();
    test_rsp_backpressure();
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
